rc_pulse_decoder: RTL and testbench

RC_PULSE_DECODER -- requirements
Module: rc_pulse_decoder

---
 rtl/drone_pkg.sv | 34 +++
 rtl/rc_input_sync.sv | 38 +++
 rtl/rc_pulse_decoder.sv | 178 +++++++++++++++++
 tb/tb_rc_pulse_decoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drone_pkg.sv
// Shared RC channel constants, decoder FSM states
// and the microsecond-to-stick-position scaling.
package drone_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_WAIT_RISE,
    ST_MEASURE
  } rc_state_e;

  localparam int unsigned RC_CENTER_US  = 1500;
  localparam int unsigned RC_OFFSET_US  = 1000;
  localparam int unsigned RC_SPAN       = 1000;

  localparam int unsigned RC_CLK_PER_US = 12;
  localparam int unsigned RC_MIN_US     = 900;
  localparam int unsigned RC_MAX_US     = 2100;
  localparam int unsigned RC_TIMEOUT_US = 50000;
  localparam int unsigned RC_RECOVER    = 3;

  localparam int unsigned RC_US_W       = 12;
  localparam logic [RC_US_W-1:0] RC_US_SAT = '1;

  function automatic logic [9:0] rc_scale(
    input logic [RC_US_W-1:0] w
  );
    logic [RC_US_W-1:0] d;
    d = w - RC_US_W'(RC_OFFSET_US);
    if (w < RC_US_W'(RC_OFFSET_US)) return '0;
    if (d > RC_US_W'(RC_SPAN)) return 10'(RC_SPAN);
    return d[9:0];
  endfunction

endpackage

// File: rtl/rc_input_sync.sv
// Two-flop synchronizer for the RC channel input
// plus a history flop for rise/fall detection.
module rc_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pwm_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/rc_pulse_decoder.sv
// RC servo pulse decoder: measures high time in us,
// publishes 0..1000 stick values, handles failsafe.
module rc_pulse_decoder
  import drone_pkg::*;
#(
  parameter int unsigned CLK_PER_US     = RC_CLK_PER_US,
  parameter int unsigned MIN_US         = RC_MIN_US,
  parameter int unsigned MAX_US         = RC_MAX_US,
  parameter int unsigned TIMEOUT_US     = RC_TIMEOUT_US,
  parameter int unsigned RECOVER_PULSES = RC_RECOVER,
  parameter logic [9:0]  FAILSAFE_VALUE = 10'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [9:0] value,
  output logic       value_valid,
  output logic       failsafe,
  output logic       pulse_err
);

  localparam int unsigned PW = $clog2(CLK_PER_US + 2);
  localparam int unsigned GW = $clog2(RECOVER_PULSES + 1);
  localparam int unsigned UW = RC_US_W;

  localparam logic [PW-1:0] PRE_TOP  = PW'(CLK_PER_US - 1);
  // two extra low samples flush the reset-cleared synchronizer
  localparam logic [PW-1:0] SYNC_TOP = PW'(CLK_PER_US + 1);
  localparam logic [UW-1:0] MIN_W    = UW'(MIN_US);
  localparam logic [UW-1:0] MAX_W    = UW'(MAX_US);
  localparam logic [15:0]   TOUT     = 16'(TIMEOUT_US);
  localparam logic [GW-1:0] GOOD_LAST = GW'(RECOVER_PULSES - 1);

  logic lvl, rise, fall;

  rc_input_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  rc_state_e     state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d, us_inc;
  logic [UW-1:0] width_q, width_d;
  logic          eval_q, eval_d;
  logic [PW-1:0] tpre_q, tpre_d;
  logic [15:0]   tout_q, tout_d;
  logic [GW-1:0] good_q, good_d;
  logic [9:0]    value_q, value_d;
  logic          vv_q, vv_d;
  logic          fs_q, fs_d;
  logic          err_q, err_d;
  logic          tout_hit, pulse_ok;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    us_d    = us_q;
    width_d = width_q;
    eval_d  = 1'b0;
    us_inc  = (us_q == RC_US_SAT) ? us_q : us_q + 1'b1;
    unique case (state_q)
      ST_SYNC: begin
        if (lvl) begin
          pre_d = '0;
        end else if (pre_q == SYNC_TOP) begin
          pre_d   = '0;
          state_d = ST_WAIT_RISE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          pre_d   = '0;
          us_d    = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (pre_q == PRE_TOP) begin
          pre_d = '0;
          us_d  = us_inc;
        end else begin
          pre_d = pre_q + 1'b1;
        end
        // the fall cycle itself still counts toward the width
        if (fall) begin
          width_d = us_d;
          eval_d  = 1'b1;
          state_d = ST_WAIT_RISE;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    tpre_d  = tpre_q + 1'b1;
    tout_d  = tout_q;
    good_d  = good_q;
    value_d = value_q;
    vv_d    = 1'b0;
    err_d   = 1'b0;
    fs_d    = fs_q;
    if (tpre_q == PRE_TOP) begin
      tpre_d = '0;
      if (tout_q != TOUT) tout_d = tout_q + 1'b1;
    end
    tout_hit = (tout_q != TOUT) && (tout_d == TOUT);
    pulse_ok = eval_q && (width_q >= MIN_W)
               && (width_q <= MAX_W);
    if (eval_q && !pulse_ok) begin
      err_d = 1'b1;
      if (fs_q) good_d = '0;
    end
    if (pulse_ok) begin
      tpre_d = '0;
      tout_d = '0;
      if (!fs_q) begin
        value_d = rc_scale(width_q);
        vv_d    = 1'b1;
      end else if (good_q == GOOD_LAST) begin
        fs_d    = 1'b0;
        good_d  = '0;
        value_d = rc_scale(width_q);
        vv_d    = 1'b1;
      end else begin
        good_d = good_q + 1'b1;
      end
    end else if (tout_hit) begin
      fs_d    = 1'b1;
      value_d = FAILSAFE_VALUE;
      vv_d    = 1'b1;
      good_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SYNC;
      pre_q   <= '0;
      us_q    <= '0;
      width_q <= '0;
      eval_q  <= 1'b0;
      tpre_q  <= '0;
      tout_q  <= '0;
      good_q  <= '0;
      value_q <= FAILSAFE_VALUE;
      vv_q    <= 1'b0;
      fs_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      us_q    <= us_d;
      width_q <= width_d;
      eval_q  <= eval_d;
      tpre_q  <= tpre_d;
      tout_q  <= tout_d;
      good_q  <= good_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = vv_q;
  assign failsafe    = fs_q;
  assign pulse_err   = err_q;

endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Scoreboard bench for rc_pulse_decoder with a
// shortened timeout and 2 clocks per microsecond.
module tb_rc_pulse_decoder;

  localparam int CPU = 2;
  localparam int TO  = 4000;
  localparam int GAP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [9:0] value;
  logic       value_valid;
  logic       failsafe;
  logic       pulse_err;

  rc_pulse_decoder #(
    .CLK_PER_US     (CPU),
    .MIN_US         (900),
    .MAX_US         (2100),
    .TIMEOUT_US     (TO),
    .RECOVER_PULSES (3),
    .FAILSAFE_VALUE (10'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .value       (value),
    .value_valid (value_valid),
    .failsafe    (failsafe),
    .pulse_err   (pulse_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic       chk_lat;
    logic [9:0] val;
    logic       fs;
  } ev_t;

  ev_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_strobe = 0;
  int last_fall_cyc = 0;
  int last_vv_cyc = 0;

  logic       m_fs;
  int         m_good;
  logic [9:0] m_val;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] exp_scale(input int w);
    if (w < 1000) return 10'd0;
    if (w > 2000) return 10'd1000;
    return 10'(w - 1000);
  endfunction

  always @(negedge clk) begin
    ev_t ev;
    if (!rst && (value_valid || pulse_err)) begin
      n_strobe = n_strobe + 1;
      if (value_valid) last_vv_cyc = cyc;
      n_chk = n_chk + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected strobe: vv=%0b err=%0b val=%0d, required none",
                 value_valid, pulse_err, value);
      end else begin
        ev = exp_q.pop_front();
        if (pulse_err !== ev.is_err || value_valid !== !ev.is_err) begin
          n_err = n_err + 1;
          $display("FAIL strobe kind: vv=%0b err=%0b, required err=%0b",
                   value_valid, pulse_err, ev.is_err);
        end
        n_chk = n_chk + 1;
        if (value !== ev.val) begin
          n_err = n_err + 1;
          $display("FAIL strobe value: got %0d, required %0d", value, ev.val);
        end
        n_chk = n_chk + 1;
        if (failsafe !== ev.fs) begin
          n_err = n_err + 1;
          $display("FAIL strobe failsafe: got %0b, required %0b",
                   failsafe, ev.fs);
        end
        if (ev.chk_lat) begin
          n_chk = n_chk + 1;
          if (cyc - last_fall_cyc != 4) begin
            n_err = n_err + 1;
            $display("FAIL strobe latency: got %0d cycles, required 4",
                     cyc - last_fall_cyc);
          end
        end
      end
    end
  end

  task automatic model_reset();
    m_fs = 1'b1;
    m_good = 0;
    m_val = 10'd0;
    exp_q.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic send_pulse(input int w);
    ev_t ev;
    if (w >= 900 && w <= 2100) begin
      if (!m_fs) begin
        m_val = exp_scale(w);
        ev = '{1'b0, 1'b1, m_val, 1'b0};
        exp_q.push_back(ev);
      end else begin
        m_good = m_good + 1;
        if (m_good == 3) begin
          m_fs = 1'b0;
          m_good = 0;
          m_val = exp_scale(w);
          ev = '{1'b0, 1'b1, m_val, 1'b0};
          exp_q.push_back(ev);
        end
      end
    end else begin
      if (m_fs) m_good = 0;
      ev = '{1'b1, 1'b1, m_val, m_fs};
      exp_q.push_back(ev);
    end
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (w * CPU) @(negedge clk);
    pwm_in = 1'b0;
    last_fall_cyc = cyc;
    repeat (GAP * CPU) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    n_chk = n_chk + 1;
    if (value !== 10'd0) begin
      n_err = n_err + 1;
      $display("FAIL reset value: got %0d, required 0", value);
    end
    n_chk = n_chk + 1;
    if (value_valid !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset value_valid: got %0b, required 0", value_valid);
    end
    n_chk = n_chk + 1;
    if (pulse_err !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset pulse_err: got %0b, required 0", pulse_err);
    end
    n_chk = n_chk + 1;
    if (failsafe !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL reset failsafe: got %0b, required 1", failsafe);
    end
    rst = 1'b0;
    model_reset();
    repeat (GAP * CPU) @(negedge clk);
  endtask

  task automatic test_partial();
    int s0;
    @(negedge clk);
    rst = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    s0 = n_strobe;
    repeat (300 * CPU) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100 * CPU) @(negedge clk);
    n_chk = n_chk + 1;
    if (n_strobe !== s0) begin
      n_err = n_err + 1;
      $display("FAIL partial strobes: got %0d, required 0", n_strobe - s0);
    end
  endtask

  task automatic test_lock();
    send_pulse(1500);
    send_pulse(1500);
    n_chk = n_chk + 1;
    if (failsafe !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL lock early failsafe: got %0b, required 1", failsafe);
    end
    send_pulse(1500);
    wait_idle();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL lock pending: got %0d events, required 0", exp_q.size());
      exp_q.delete();
    end
    n_chk = n_chk + 1;
    if (value !== 10'd500 || failsafe !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL lock state: got %0d/%0b, required 500/0", value, failsafe);
    end
  endtask

  task automatic test_values();
    int ws[5] = '{1000, 2000, 950, 900, 2100};
    for (int i = 0; i < 5; i++) send_pulse(ws[i]);
    wait_idle();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL values pending: got %0d events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_errors();
    int ws[4] = '{2500, 1300, 800, 2101};
    for (int i = 0; i < 4; i++) send_pulse(ws[i]);
    wait_idle();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL errors pending: got %0d events, required 0", exp_q.size());
      exp_q.delete();
    end
    n_chk = n_chk + 1;
    if (value !== m_val) begin
      n_err = n_err + 1;
      $display("FAIL errors held value: got %0d, required %0d", value, m_val);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int hit;
    ev_t ev;
    t0 = last_vv_cyc;
    m_fs = 1'b1;
    m_good = 0;
    m_val = 10'd0;
    ev = '{1'b0, 1'b0, 10'd0, 1'b1};
    exp_q.push_back(ev);
    hit = -1;
    for (int i = 0; i < (TO + 200) * CPU && hit < 0; i++) begin
      @(negedge clk);
      if (failsafe === 1'b1) hit = cyc;
    end
    n_chk = n_chk + 1;
    if (hit < 0) begin
      n_err = n_err + 1;
      $display("FAIL timeout: failsafe never set, required set");
    end else if (hit - t0 != TO * CPU) begin
      n_err = n_err + 1;
      $display("FAIL timeout delay: got %0d cycles, required %0d",
               hit - t0, TO * CPU);
    end
    wait_idle();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0 || value !== 10'd0) begin
      n_err = n_err + 1;
      $display("FAIL timeout state: got %0d pending val=%0d, required 0 val=0",
               exp_q.size(), value);
      exp_q.delete();
    end
  endtask

  task automatic test_recovery();
    send_pulse(1050);
    send_pulse(1050);
    send_pulse(800);
    send_pulse(1050);
    send_pulse(1050);
    n_chk = n_chk + 1;
    if (failsafe !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL recovery early: failsafe got %0b, required 1", failsafe);
    end
    send_pulse(1050);
    wait_idle();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL recovery pending: got %0d events, required 0",
               exp_q.size());
      exp_q.delete();
    end
    n_chk = n_chk + 1;
    if (failsafe !== 1'b0 || value !== 10'd50) begin
      n_err = n_err + 1;
      $display("FAIL recovery state: got %0b/%0d, required 0/50",
               failsafe, value);
    end
  endtask

  task automatic test_mid_reset();
    int s0;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (500 * CPU) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk = n_chk + 1;
    if (value !== 10'd0 || failsafe !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL mid reset outputs: got %0d/%0b, required 0/1",
               value, failsafe);
    end
    n_chk = n_chk + 1;
    if (value_valid !== 1'b0 || pulse_err !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL mid reset strobes: got %0b/%0b, required 0/0",
               value_valid, pulse_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    s0 = n_strobe;
    repeat (300 * CPU) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100 * CPU) @(negedge clk);
    n_chk = n_chk + 1;
    if (n_strobe !== s0) begin
      n_err = n_err + 1;
      $display("FAIL mid reset strobes after: got %0d, required 0",
               n_strobe - s0);
    end
  endtask

  task automatic test_stuck();
    ev_t ev;
    ev = '{1'b0, 1'b0, 10'd0, 1'b1};
    exp_q.push_back(ev);
    ev = '{1'b1, 1'b1, 10'd0, 1'b1};
    exp_q.push_back(ev);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (4200 * CPU) @(negedge clk);
    pwm_in = 1'b0;
    last_fall_cyc = cyc;
    repeat (GAP * CPU) @(negedge clk);
    wait_idle();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL stuck pending: got %0d events, required 0", exp_q.size());
      exp_q.delete();
    end
    n_chk = n_chk + 1;
    if (failsafe !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL stuck failsafe: got %0b, required 1", failsafe);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_partial();
    test_lock();
    test_values();
    test_errors();
    test_timeout();
    test_recovery();
    test_mid_reset();
    test_stuck();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
